// File: rtl/time_field_pkg.sv
// Shared types and BCD helpers for the time field counter and its adjust FSMs.
package time_field_pkg;

    localparam int VALUE_W = 7;

    typedef logic [VALUE_W-1:0] value_t;
    typedef logic [3:0]         bcd_t;

    typedef enum logic [1:0] {
        ADJ_IDLE   = 2'd0,
        ADJ_DELAY  = 2'd1,
        ADJ_REPEAT = 2'd2
    } adj_state_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t ones;
    } bcd_pair_t;

    function automatic bcd_pair_t bin_to_bcd(input value_t v);
        bcd_pair_t r;
        r.tens = bcd_t'(v / value_t'(10));
        r.ones = bcd_t'(v % value_t'(10));
        return r;
    endfunction

    function automatic logic bcd_valid(input bcd_pair_t b);
        return (b.tens <= 4'd9) && (b.ones <= 4'd9);
    endfunction

    function automatic logic [7:0] bcd_to_bin(input bcd_pair_t b);
        logic [7:0] t;
        logic [7:0] o;
        t = {4'd0, b.tens};
        o = {4'd0, b.ones};
        return (t * 8'd10) + o;
    endfunction

endpackage

// File: rtl/time_field_counter_if.sv
// Control and display bundle of one time field: count/adjust/load inputs, BCD and status outputs.
interface time_field_counter_if;
    import time_field_pkg::*;

    logic       tick;
    logic       down;
    logic       pause;
    logic       add_btn;
    logic       sub_btn;
    logic       load;
    logic [7:0] load_bcd;
    bcd_t       tens;
    bcd_t       ones;
    logic       carry;
    logic       at_max;
    logic       at_zero;
    logic       load_err;

    modport master (
        output tick, down, pause, add_btn, sub_btn, load, load_bcd,
        input  tens, ones, carry, at_max, at_zero, load_err
    );

    modport slave (
        input  tick, down, pause, add_btn, sub_btn, load, load_bcd,
        output tens, ones, carry, at_max, at_zero, load_err
    );

endinterface

// File: rtl/time_field_counter_adjust.sv
// One adjust button: rising-edge step, then hold-to-repeat after an initial delay.
module adjust_button_fsm
    import time_field_pkg::*;
#(
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic force_idle,
    output logic step
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t DELAY_C  = cnt_t'(REPEAT_DELAY);
    localparam cnt_t PERIOD_C = cnt_t'(REPEAT_PERIOD);
    localparam cnt_t ONE_C    = cnt_t'(1);

    adj_state_t state, state_nx;
    cnt_t       cnt, cnt_nx;
    logic       prev;
    logic       rise;

    assign rise = btn & ~prev;

    // prev resets high so a button held through reset must be released first
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ADJ_IDLE;
            cnt   <= '0;
            prev  <= 1'b1;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            prev  <= btn;
        end
    end

    // cnt holds the number of held cycles since the last step
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        step     = 1'b0;
        if (force_idle || !btn) begin
            state_nx = ADJ_IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                ADJ_IDLE: begin
                    if (rise) begin
                        step     = 1'b1;
                        state_nx = ADJ_DELAY;
                        cnt_nx   = ONE_C;
                    end
                end
                ADJ_DELAY: begin
                    if (cnt == DELAY_C) begin
                        step     = 1'b1;
                        state_nx = ADJ_REPEAT;
                        cnt_nx   = ONE_C;
                    end else begin
                        cnt_nx = cnt + ONE_C;
                    end
                end
                ADJ_REPEAT: begin
                    if (cnt == PERIOD_C) begin
                        step   = 1'b1;
                        cnt_nx = ONE_C;
                    end else begin
                        cnt_nx = cnt + ONE_C;
                    end
                end
                default: begin
                    state_nx = ADJ_IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/time_field_counter.sv
// Modulo-(MAX_VALUE+1) time field with tick count up/down, button adjust, BCD load and cascade carry.
module time_field_counter
    import time_field_pkg::*;
#(
    parameter int MAX_VALUE     = 59,
    parameter int ADJ_STEP      = 2,
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 4
) (
    input logic                 clk,
    input logic                 reset,
    time_field_counter_if.slave bus
);

    localparam value_t MAX_V  = value_t'(MAX_VALUE);
    localparam value_t STEP_V = value_t'(ADJ_STEP);
    // Adding ADJ_STEP wraps exactly when value >= MAX_VALUE+1-ADJ_STEP
    localparam value_t WRAP_V = value_t'(MAX_VALUE + 1 - ADJ_STEP);
    localparam value_t ONE_V  = value_t'(1);

    value_t    value, value_nx;
    bcd_pair_t bcd_q;
    logic      carry_q, carry_nx;
    logic      err_q, err_nx;
    logic      at_max_q, at_zero_q;
    logic      lock;
    logic      both_held;
    logic      force_idle;
    logic      add_step, sub_step;
    logic      adj_up, adj_dn;
    bcd_pair_t ld_bcd;
    logic [7:0] ld_bin;
    logic      ld_ok;

    assign both_held  = bus.add_btn & bus.sub_btn;
    assign force_idle = bus.load | both_held | lock;

    adjust_button_fsm #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_add (
        .clk       (clk),
        .reset     (reset),
        .btn       (bus.add_btn),
        .force_idle(force_idle),
        .step      (add_step)
    );

    adjust_button_fsm #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_sub (
        .clk       (clk),
        .reset     (reset),
        .btn       (bus.sub_btn),
        .force_idle(force_idle),
        .step      (sub_step)
    );

    // Opposing steps in the same cycle cancel out
    assign adj_up = add_step & ~sub_step;
    assign adj_dn = sub_step & ~add_step;

    assign ld_bcd = bus.load_bcd;
    assign ld_bin = bcd_to_bin(ld_bcd);
    assign ld_ok  = bcd_valid(ld_bcd) && (ld_bin <= 8'(MAX_VALUE));

    always_comb begin
        value_nx = value;
        carry_nx = 1'b0;
        err_nx   = 1'b0;
        if (bus.load) begin
            if (ld_ok) value_nx = value_t'(ld_bin);
            else       err_nx   = 1'b1;
        end else if (adj_up) begin
            value_nx = (value >= WRAP_V) ? (value - WRAP_V) : (value + STEP_V);
        end else if (adj_dn) begin
            value_nx = (value >= STEP_V) ? (value - STEP_V) : (value + WRAP_V);
        end else if (bus.tick && !bus.pause) begin
            if (bus.down) begin
                if (value == '0) begin
                    value_nx = MAX_V;
                    carry_nx = 1'b1;
                end else begin
                    value_nx = value - ONE_V;
                end
            end else begin
                if (value == MAX_V) begin
                    value_nx = '0;
                    carry_nx = 1'b1;
                end else begin
                    value_nx = value + ONE_V;
                end
            end
        end
    end

    // Status and BCD digits are registered from value_nx so they line up with value
    always_ff @(posedge clk) begin
        if (reset) begin
            value     <= '0;
            bcd_q     <= '0;
            carry_q   <= 1'b0;
            err_q     <= 1'b0;
            at_max_q  <= 1'b0;
            at_zero_q <= 1'b1;
            lock      <= 1'b0;
        end else begin
            value     <= value_nx;
            bcd_q     <= bin_to_bcd(value_nx);
            carry_q   <= carry_nx;
            err_q     <= err_nx;
            at_max_q  <= (value_nx == MAX_V);
            at_zero_q <= (value_nx == '0);
            if (both_held)                          lock <= 1'b1;
            else if (!bus.add_btn && !bus.sub_btn)  lock <= 1'b0;
        end
    end

    assign bus.tens     = bcd_q.tens;
    assign bus.ones     = bcd_q.ones;
    assign bus.carry    = carry_q;
    assign bus.load_err = err_q;
    assign bus.at_max   = at_max_q;
    assign bus.at_zero  = at_zero_q;

endmodule

// File: doc/time_field_counter.md
Name: time_field_counter

Overview:
Parametrised successor to the per-digit minutes counter. It holds one clock time field (seconds, minutes or hours) as a modulo-(MAX_VALUE+1) value and presents it as two BCD digits. It counts up or down on a one-cycle tick and supports pause. It has button-driven ±ADJ_STEP adjust with edge detection and hold-to-repeat, BCD load, and a cascade carry/borrow pulse that drives the next field's tick.

Parameters:
MAX_VALUE, 59, highest field value; the field wraps at MAX_VALUE+1; legal range 1..99
ADJ_STEP, 2, magnitude of one adjust step; legal range 1..MAX_VALUE
REPEAT_DELAY, 16, cycles from a button's rising edge to its first auto-repeat step (≥2)
REPEAT_PERIOD, 4, cycles between later auto-repeat steps while the button is held (≥1)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high; clears all state
tick  input  1  one-cycle count enable (the previous field's carry, or a prescaler)
down  input  1  count mode: 0 counts up, 1 counts down
pause  input  1  1 ignores tick; adjust and load still work
add_btn  input  1  level input, already synchronised; rising edge or hold steps +ADJ_STEP
sub_btn  input  1  level input, already synchronised; rising edge or hold steps −ADJ_STEP
load  input  1  one-cycle load strobe
load_bcd  input  8  BCD load value, [7:4] tens and [3:0] ones
tens  output  4  BCD tens digit
ones  output  4  BCD ones digit
carry  output  1  one-cycle pulse when a tick wraps the field (carry when up, borrow when down)
at_max  output  1  value == MAX_VALUE
at_zero  output  1  value == 0
load_err  output  1  one-cycle pulse when a load is rejected

Behaviour:
- State: binary value reg (7 bits), two adjust FSMs, previous-sample regs for both buttons. All outputs are registered or decoded directly from registers.
- Reset (sync, active-high):
  - value := 0, so tens=0, ones=0, at_zero=1, at_max=0.
  - carry=0, load_err=0.
  - FSMs go to ADJ_IDLE; button previous-samples := 1, so a button held through reset must be released before it acts.
- Latency: every update shows on the outputs the cycle after the qualifying input; carry and load_err assert in that same cycle.
- Per-cycle priority: reset > load > adjust step > tick. A lower-priority event in the same cycle is dropped (no carry is generated).
- Load:
  - Accepted only if both digits ≤9 and the decoded value ≤ MAX_VALUE.
  - If rejected, value is unchanged and load_err pulses.
  - Load aborts both FSMs to ADJ_IDLE.
- Adjust FSM (one per button):
  - ADJ_IDLE → ADJ_DELAY on a rising edge; emits one step.
  - ADJ_DELAY → ADJ_REPEAT after REPEAT_DELAY cycles held; emits one step.
  - ADJ_REPEAT emits one step every REPEAT_PERIOD cycles held.
  - Releasing the button returns to ADJ_IDLE from any state.
- Adjust arithmetic:
  - Up step: value := (value + ADJ_STEP) mod (MAX_VALUE+1).
  - Down step: value := (value − ADJ_STEP) mod (MAX_VALUE+1), non-negative result.
  - Adjust wraps never raise carry.
- Both buttons:
  - Both step requests in one cycle: they cancel and value is unchanged.
  - Both buttons high: both FSMs forced to ADJ_IDLE and held there until both are released.
- Tick (pause=0):
  - Up: value+1; at MAX_VALUE it wraps to 0 with carry=1.
  - Down: value−1; at 0 it wraps to MAX_VALUE with carry=1.
  - With pause=1, tick has no effect and carry stays 0.
- down may change at any cycle and applies to the next tick only.
- BCD outputs: tens = value/10, ones = value mod 10. Decoded from the value reg, glitch-free at the output flops or via a registered BCD shadow (implementer's choice). Values are never >9 per digit.

Decomposition:
- Package time_field_pkg:
  - adj_state_t enum {ADJ_IDLE, ADJ_DELAY, ADJ_REPEAT}
  - bcd_t (logic [3:0])
  - function bin_to_bcd (7-bit value → 2×bcd_t)
  - function bcd_valid
- Sub-module adjust_button_fsm: edge detect, delay/period counter and step pulse output. Instantiated once per button, with a force_idle input for the both-buttons and load cases.

Test Plan:
1. Reset with add_btn held → tens=0, ones=0, at_zero=1, carry=0; no step occurs until add_btn is released and pressed again.
2. Load 0x58, down=0, two ticks → 59 (at_max=1), then 00 with carry=1 for exactly one cycle.
3. down=1 at 00, one tick → 59 with carry=1. Next tick → 58 with carry=0.
4. pause=1, five ticks → unchanged. add_btn edge at 00 → 02. sub_btn edge at 01 → 59, carry=0.
5. add_btn held 24 cycles from 00 → steps at cycles 0, 16 and 20, final value 06. Release, then press sub_btn 1 cycle → 04.
6. Simultaneous:
   - add and sub edges in one cycle → no change.
   - load 0x6A → value unchanged, load_err=1 for one cycle.
   - tick and load 0x30 in one cycle → 30, carry=0.
   - reset during ADJ_REPEAT → 00, FSM in ADJ_IDLE.
